dbg_dump_engine: RTL and testbench
==================================

Name: dbg_dump_engine

Overview:
- Parametrised successor to the single-purpose debug-unit dump path: a framed, byte-serial state dump engine.
- On request it snapshots PC, a configurable range of the register file, and a configurable window of data memory, serialises each word into UART-width bytes, and streams them through a ready/valid byte interface into the UART TX FIFO.
- Frames carry a header byte and an XOR checksum byte. Sits between cpu_core debug read ports and the UART TX FIFO.

Parameters:
- NB_WORD, 32, width of PC/register/DMEM words; must be a multiple of NB_UART_DATA
- NB_UART_DATA, 8, byte width on TX side
- REG_ADDR_WIDTH, 5, register file address width
- DMEM_ADDR_WIDTH, 5, data memory word-address width
- BIG_ENDIAN, 0, 0 = least-significant byte first, 1 = most-significant byte first
- HEADER, 8'h5A, frame start byte

Ports:
- clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle dump request
- i_abort  in  1  terminate frame immediately
- i_mask  in  3  section enables: [0] PC, [1] registers, [2] DMEM
- i_dmem_base  in  DMEM_ADDR_WIDTH  first DMEM word
- i_dmem_count  in  DMEM_ADDR_WIDTH+1  DMEM words to dump (0 = none)
- i_pc  in  NB_WORD  current PC
- o_reg_addr  out  REG_ADDR_WIDTH  register read address
- i_reg_data  in  NB_WORD  register data, valid 1 cycle after address
- o_dmem_addr  out  DMEM_ADDR_WIDTH  DMEM read address
- i_dmem_data  in  NB_WORD  DMEM data, valid 1 cycle after address
- o_tx_data  out  NB_UART_DATA  byte to TX FIFO
- o_tx_valid  out  1  byte valid
- i_tx_ready  in  1  TX FIFO not full
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: async, i_rst_n low forces IDLE. All outputs 0. Internal checksum, counters and shift register 0.
- Transfer rule: a byte is consumed on the cycle o_tx_valid & i_tx_ready. While o_tx_valid & !i_tx_ready, o_tx_data holds stable. o_tx_valid never drops without a transfer, except on abort/reset.
- FSM states: IDLE, HDR, ADDR, CAPT, SEND, CSUM, DONE.
- IDLE: i_start latches i_mask, i_dmem_base and i_dmem_count, clears the checksum, and goes to HDR. o_busy is high from the next cycle. i_start is ignored when not IDLE.
- HDR: drives HEADER with valid. On transfer, goes to the first enabled section, or to CSUM if the mask is 0.
- Section order is PC, then registers 0..2^REG_ADDR_WIDTH-1, then DMEM base..base+count-1.
- DMEM address wraps modulo 2^DMEM_ADDR_WIDTH. A DMEM section with count 0 is skipped.
- ADDR: drives o_reg_addr/o_dmem_addr for the current word. PC needs no address; the PC path still takes one ADDR cycle for uniform timing.
- CAPT: loads i_pc, i_reg_data or i_dmem_data into the shift register. Fixed 2-cycle read latency per word (ADDR + CAPT).
- SEND: emits NB_WORD/NB_UART_DATA bytes in BIG_ENDIAN order. Each transferred byte is XORed into the checksum. After the last byte, goes to ADDR for the next word, the next section, or CSUM.
- CSUM: emits the checksum byte, which is the XOR of all payload bytes excluding the header. The checksum byte itself is not folded. On transfer, goes to DONE.
- DONE: o_done is high for exactly one cycle, o_busy drops, then IDLE. A new i_start in DONE is ignored; it is accepted from IDLE on the next cycle.
- Frame length: 2 + mask[0]*B + mask[1]*2^REG_ADDR_WIDTH*B + mask[2]*count*B bytes, where B = NB_WORD/NB_UART_DATA.
- i_abort: in any non-IDLE state, next cycle is IDLE. o_tx_valid, o_busy and o_done are 0, with no done pulse; a pending byte is dropped. i_abort in IDLE has no effect. Abort has priority over a simultaneous transfer.
- Back-pressure: i_tx_ready held high gives 1 byte/cycle within a word, plus 2 stall cycles per word.
- Address outputs hold their last value outside ADDR/CAPT.

Test Plan:
- PC only: mask=3'b001, i_pc=32'h0000_0104, LE, ready=1 -> bytes 5A,04,01,00,00,05. o_done pulses once, after the last byte.
- Registers with BIG_ENDIAN=1: mask=3'b010, reg k = 32'h1000_0000+k -> 130 bytes, reg0 bytes = 10,00,00,00. Checksum = XOR of all 128 payload bytes.
- DMEM wrap: base=30, count=4, mask=3'b100 -> DMEM addresses 30,31,0,1 in order; 18 bytes total.
- Back-pressure: i_tx_ready toggles 1/0 per cycle during a PC dump -> identical byte sequence. o_tx_data is stable during every stalled cycle.
- Abort: i_abort asserted during register 3 SEND -> IDLE next cycle, o_busy=0, no o_done. A following i_start produces a complete, correct frame.
- Mask 0 and start while busy: mask=0 -> bytes 5A,00 then done. An i_start pulse mid-frame has no effect on frame length.

Source files
------------

// File: rtl/dbg_dump_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : dbg_dump_tx_if
// Description : Byte-wide ready/valid stream from the dump engine to TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface dbg_dump_tx_if #(
    parameter int NB_UART_DATA = 8
);
    logic [NB_UART_DATA-1:0] data;
    logic                    valid;
    logic                    ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/dbg_dump_engine.sv
`default_nettype none
// ============================================================================
// Module      : dbg_dump_engine
// Description : Framed byte-serial dump of PC, register file and a DMEM window.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_dump_engine #(
    parameter int                      NB_WORD         = 32,
    parameter int                      NB_UART_DATA    = 8,
    parameter int                      REG_ADDR_WIDTH  = 5,
    parameter int                      DMEM_ADDR_WIDTH = 5,
    parameter bit                      BIG_ENDIAN      = 1'b0,
    parameter logic [NB_UART_DATA-1:0] HEADER          = 8'h5A
) (
    input  wire                        clk,
    input  wire                        i_rst_n,
    input  wire                        i_start,
    input  wire                        i_abort,
    input  wire  [2:0]                 i_mask,
    input  wire  [DMEM_ADDR_WIDTH-1:0] i_dmem_base,
    input  wire  [DMEM_ADDR_WIDTH:0]   i_dmem_count,
    input  wire  [NB_WORD-1:0]         i_pc,
    output logic [REG_ADDR_WIDTH-1:0]  o_reg_addr,
    input  wire  [NB_WORD-1:0]         i_reg_data,
    output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
    input  wire  [NB_WORD-1:0]         i_dmem_data,
    dbg_dump_tx_if.master              tx,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int c_NB_BYTES = NB_WORD / NB_UART_DATA;
    localparam int c_BCNT_W   = (c_NB_BYTES > 1) ? $clog2(c_NB_BYTES) : 1;
    localparam logic [c_BCNT_W-1:0] c_LAST_BYTE = c_BCNT_W'(c_NB_BYTES - 1);

    localparam logic [2:0] c_NX_PC         = 3'd0;
    localparam logic [2:0] c_NX_REG_FIRST  = 3'd1;
    localparam logic [2:0] c_NX_REG_NEXT   = 3'd2;
    localparam logic [2:0] c_NX_DMEM_FIRST = 3'd3;
    localparam logic [2:0] c_NX_DMEM_NEXT  = 3'd4;
    localparam logic [2:0] c_NX_CSUM       = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_ADDR = 3'd2,
        S_CAPT = 3'd3,
        S_SEND = 3'd4,
        S_CSUM = 3'd5,
        S_DONE = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC   = 2'd0,
        SEC_REG  = 2'd1,
        SEC_DMEM = 2'd2
    } sect_t;

    state_t                      r_state;
    sect_t                       r_sect;
    logic [2:0]                  r_mask;
    logic [DMEM_ADDR_WIDTH-1:0]  r_dbase;
    logic [DMEM_ADDR_WIDTH:0]    r_dcount;
    logic [DMEM_ADDR_WIDTH:0]    r_dleft;
    logic [REG_ADDR_WIDTH-1:0]   r_reg_addr;
    logic [DMEM_ADDR_WIDTH-1:0]  r_dmem_addr;
    logic [NB_WORD-1:0]          r_shift;
    logic [c_BCNT_W-1:0]         r_byte_cnt;
    logic [NB_UART_DATA-1:0]     r_csum;
    logic [NB_UART_DATA-1:0]     r_tx_data;
    logic                        r_tx_valid;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_xfer;
    logic                        w_from_hdr;
    logic                        w_dmem_en;
    logic                        w_more_reg;
    logic                        w_more_dmem;
    logic                        w_last_byte;
    logic [2:0]                  w_next_step;
    logic [NB_WORD-1:0]          w_capt_word;
    logic [NB_WORD-1:0]          w_shift_nxt;
    logic [NB_UART_DATA-1:0]     w_csum_nxt;

    function automatic logic [NB_UART_DATA-1:0] f_lead_byte(input logic [NB_WORD-1:0] word);
        if (BIG_ENDIAN) return word[NB_WORD-1 -: NB_UART_DATA];
        else            return word[NB_UART_DATA-1:0];
    endfunction

    function automatic logic [NB_WORD-1:0] f_consume(input logic [NB_WORD-1:0] word);
        if (BIG_ENDIAN) return word << NB_UART_DATA;
        else            return word >> NB_UART_DATA;
    endfunction

    assign w_xfer      = r_tx_valid & tx.ready;
    assign w_from_hdr  = (r_state == S_HDR);
    assign w_dmem_en   = r_mask[2] && (r_dcount != '0);
    // r_sect is stale while in HDR, so section continuation only applies after a word.
    assign w_more_reg  = !w_from_hdr && (r_sect == SEC_REG) && (r_reg_addr != '1);
    assign w_more_dmem = !w_from_hdr && (r_sect == SEC_DMEM) &&
                         (r_dleft > (DMEM_ADDR_WIDTH + 1)'(1));
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_shift_nxt = f_consume(r_shift);
    assign w_csum_nxt  = (r_state == S_SEND) ? (r_csum ^ r_tx_data) : r_csum;

    always_comb begin
        w_next_step = c_NX_CSUM;
        if (w_from_hdr && r_mask[0])
            w_next_step = c_NX_PC;
        else if (w_more_reg)
            w_next_step = c_NX_REG_NEXT;
        else if (w_more_dmem)
            w_next_step = c_NX_DMEM_NEXT;
        else if ((w_from_hdr || r_sect == SEC_PC) && r_mask[1])
            w_next_step = c_NX_REG_FIRST;
        else if ((w_from_hdr || r_sect != SEC_DMEM) && w_dmem_en)
            w_next_step = c_NX_DMEM_FIRST;
    end

    always_comb begin
        w_capt_word = i_dmem_data;
        case (r_sect)
            SEC_PC:  w_capt_word = i_pc;
            SEC_REG: w_capt_word = i_reg_data;
            default: w_capt_word = i_dmem_data;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sect      <= SEC_PC;
            r_mask      <= '0;
            r_dbase     <= '0;
            r_dcount    <= '0;
            r_dleft     <= '0;
            r_reg_addr  <= '0;
            r_dmem_addr <= '0;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_csum      <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_abort && (r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mask     <= i_mask;
                        r_dbase    <= i_dmem_base;
                        r_dcount   <= i_dmem_count;
                        r_csum     <= '0;
                        r_busy     <= 1'b1;
                        r_tx_data  <= HEADER;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR, S_SEND: begin
                    if (w_xfer) begin
                        if (r_state == S_SEND)
                            r_csum <= w_csum_nxt;
                        if ((r_state == S_SEND) && !w_last_byte) begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_shift    <= w_shift_nxt;
                            r_tx_data  <= f_lead_byte(w_shift_nxt);
                        end else begin
                            // Word (or header) finished: select the next word's address.
                            r_tx_valid <= 1'b0;
                            r_state    <= S_ADDR;
                            case (w_next_step)
                                c_NX_PC: r_sect <= SEC_PC;
                                c_NX_REG_FIRST: begin
                                    r_sect     <= SEC_REG;
                                    r_reg_addr <= '0;
                                end
                                c_NX_REG_NEXT: r_reg_addr <= r_reg_addr + 1'b1;
                                c_NX_DMEM_FIRST: begin
                                    r_sect      <= SEC_DMEM;
                                    r_dmem_addr <= r_dbase;
                                    r_dleft     <= r_dcount;
                                end
                                c_NX_DMEM_NEXT: begin
                                    r_dmem_addr <= r_dmem_addr + 1'b1;
                                    r_dleft     <= r_dleft - 1'b1;
                                end
                                default: begin
                                    r_state    <= S_CSUM;
                                    r_tx_valid <= 1'b1;
                                    r_tx_data  <= w_csum_nxt;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: r_state <= S_CAPT;
                S_CAPT: begin
                    r_shift    <= w_capt_word;
                    r_tx_data  <= f_lead_byte(w_capt_word);
                    r_tx_valid <= 1'b1;
                    r_byte_cnt <= '0;
                    r_state    <= S_SEND;
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx.data     = r_tx_data;
    assign tx.valid    = r_tx_valid;
    assign o_reg_addr  = r_reg_addr;
    assign o_dmem_addr = r_dmem_addr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dbg_dump_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbg_dump_engine
// Description : Scoreboarded bench driving little- and big-endian engines in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_dump_engine;

    typedef struct {
        logic [2:0]  mask;
        logic [31:0] pc;
        logic [4:0]  base;
        logic [5:0]  cnt;
        int          mode;          // 0: ready=1, 1: toggle, 2: random
        bit          hand;          // use hand-written PC-only byte list
        bit          mid_start;
        bit          start_in_done;
        int          exp_len;
    } vec_t;

    logic        clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_abort;
    logic [2:0]  i_mask;
    logic [4:0]  i_dmem_base;
    logic [5:0]  i_dmem_count;
    logic [31:0] i_pc;
    logic        tx_ready;

    logic [4:0]  reg_a_le, reg_a_be, dm_a_le, dm_a_be;
    logic [31:0] reg_d_le, reg_d_be, dm_d_le, dm_d_be;
    logic        busy_le, busy_be, done_le, done_be;

    int          n_checks;
    int          n_pass;
    int          rx_cnt   [2];
    int          done_cnt [2];
    logic        prev_stall [2];
    logic [7:0]  prev_data  [2];
    logic        prev_abort;
    logic [7:0]  q_le [$];
    logic [7:0]  q_be [$];
    vec_t        vecs [8];

    dbg_dump_tx_if #(.NB_UART_DATA(8)) tx_le ();
    dbg_dump_tx_if #(.NB_UART_DATA(8)) tx_be ();
    assign tx_le.ready = tx_ready;
    assign tx_be.ready = tx_ready;

    dbg_dump_engine #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_mask(i_mask), .i_dmem_base(i_dmem_base), .i_dmem_count(i_dmem_count),
        .i_pc(i_pc), .o_reg_addr(reg_a_le), .i_reg_data(reg_d_le),
        .o_dmem_addr(dm_a_le), .i_dmem_data(dm_d_le), .tx(tx_le),
        .o_busy(busy_le), .o_done(done_le)
    );

    dbg_dump_engine #(.BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_mask(i_mask), .i_dmem_base(i_dmem_base), .i_dmem_count(i_dmem_count),
        .i_pc(i_pc), .o_reg_addr(reg_a_be), .i_reg_data(reg_d_be),
        .o_dmem_addr(dm_a_be), .i_dmem_data(dm_d_be), .tx(tx_be),
        .o_busy(busy_be), .o_done(done_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return 32'h1000_0000 + {27'd0, a};
    endfunction

    function automatic logic [31:0] dmem_val(input logic [4:0] a);
        return 32'hC0DE_0000 ^ {19'd0, a, 3'd0, a};
    endfunction

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        reg_d_le <= reg_val(reg_a_le);
        reg_d_be <= reg_val(reg_a_be);
        dm_d_le  <= dmem_val(dm_a_le);
        dm_d_be  <= dmem_val(dm_a_be);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_byte(input int w, input logic [7:0] b);
        if (w == 0) q_le.push_back(b);
        else        q_be.push_back(b);
    endtask

    task automatic push_frame(input int w, input logic [2:0] m, input logic [31:0] pc,
                              input logic [4:0] base, input logic [5:0] cnt);
        logic [31:0] words [$];
        logic [7:0]  cs;
        logic [7:0]  b;
        words = {};
        if (m[0]) words.push_back(pc);
        if (m[1]) for (int k = 0; k < 32; k++) words.push_back(reg_val(5'(k)));
        if (m[2]) for (int k = 0; k < int'(cnt); k++) words.push_back(dmem_val(5'(int'(base) + k)));
        push_byte(w, 8'h5A);
        cs = 8'h00;
        foreach (words[i]) begin
            for (int j = 0; j < 4; j++) begin
                b = (w == 1) ? words[i][8*(3-j) +: 8] : words[i][8*j +: 8];
                cs ^= b;
                push_byte(w, b);
            end
        end
        push_byte(w, cs);
    endtask

    task automatic mon(input int w, input logic v, input logic [7:0] d, input logic dn);
        logic [7:0] e;
        if (prev_stall[w] && !prev_abort) begin
            check($sformatf("stall_valid_hold[%0d]", w), 64'(v), 64'd1);
            check($sformatf("stall_data_hold[%0d]", w), 64'(d), 64'(prev_data[w]));
        end
        if (v && tx_ready && !i_abort) begin
            rx_cnt[w]++;
            if ((w == 0 && q_le.size() == 0) || (w == 1 && q_be.size() == 0)) begin
                check($sformatf("unexpected_byte[%0d]", w), 64'd1, 64'd0);
            end else begin
                if (w == 0) e = q_le.pop_front();
                else        e = q_be.pop_front();
                check($sformatf("byte[%0d] #%0d", w, rx_cnt[w]), 64'(d), 64'(e));
            end
        end
        if (dn) begin
            done_cnt[w]++;
            check($sformatf("done_after_last[%0d]", w),
                  64'((w == 0) ? q_le.size() : q_be.size()), 64'd0);
        end
        prev_stall[w] = v && !tx_ready;
        prev_data[w]  = d;
    endtask

    always @(negedge clk) begin
        if (i_rst_n) begin
            mon(0, tx_le.valid, tx_le.data, done_le);
            mon(1, tx_be.valid, tx_be.data, done_be);
            prev_abort = i_abort;
        end
    end

    task automatic clear_counts();
        q_le.delete();
        q_be.delete();
        for (int w = 0; w < 2; w++) begin
            rx_cnt[w]     = 0;
            done_cnt[w]   = 0;
            prev_stall[w] = 1'b0;
        end
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int cyc;
        clear_counts();
        if (v.hand) begin
            q_le = '{8'h5A, 8'h04, 8'h01, 8'h00, 8'h00, 8'h05};
            q_be = '{8'h5A, 8'h00, 8'h00, 8'h01, 8'h04, 8'h05};
        end else begin
            push_frame(0, v.mask, v.pc, v.base, v.cnt);
            push_frame(1, v.mask, v.pc, v.base, v.cnt);
        end
        i_mask = v.mask; i_pc = v.pc; i_dmem_base = v.base; i_dmem_count = v.cnt;
        tx_ready = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check($sformatf("v%0d busy_after_start", idx), 64'({busy_le, busy_be}), 64'd3);
        cyc = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && cyc < 3000) begin
            i_start = 1'b0;
            if (v.mid_start && cyc == 10) begin
                i_start = 1'b1;
                i_mask = 3'b000;
                i_dmem_count = 6'd0;
            end
            if (v.start_in_done && done_le) i_start = 1'b1;
            case (v.mode)
                1:       tx_ready = (cyc % 2 == 0) ? 1'b0 : 1'b1;
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        i_start = 1'b0;
        tx_ready = 1'b1;
        check($sformatf("v%0d frame_timeout", idx), 64'(cyc >= 3000), 64'd0);
        repeat (4) @(negedge clk);
        check($sformatf("v%0d len_le", idx), 64'(rx_cnt[0]), 64'(v.exp_len));
        check($sformatf("v%0d len_be", idx), 64'(rx_cnt[1]), 64'(v.exp_len));
        check($sformatf("v%0d done_pulses", idx), 64'({done_cnt[0], done_cnt[1]}), {32'd1, 32'd1});
        check($sformatf("v%0d idle_after", idx), 64'({busy_le, busy_be, tx_le.valid}), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_abort();
        int cyc;
        clear_counts();
        push_frame(0, 3'b010, 32'h0, 5'd0, 6'd0);
        push_frame(1, 3'b010, 32'h0, 5'd0, 6'd0);
        i_mask = 3'b010; tx_ready = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        // Byte 14 of the stream is the first byte of register 3.
        cyc = 0;
        while (rx_cnt[0] < 14 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reach_reg3", 64'(cyc >= 500), 64'd0);
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        @(negedge clk);
        check("abort_idle", 64'({busy_le, busy_be, tx_le.valid, tx_be.valid, done_le, done_be}), 64'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", 64'(done_cnt[0] + done_cnt[1]), 64'd0);
        check("abort_stays_idle", 64'({busy_le, tx_le.valid}), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        prev_abort = 1'b0;
        clear_counts();
        i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_mask = 3'b000;
        i_dmem_base = 5'd0; i_dmem_count = 6'd0; i_pc = 32'h0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid_busy_done", 64'({tx_le.valid, busy_le, done_le, tx_be.valid, busy_be, done_be}), 64'd0);
        check("reset_data", 64'({tx_le.data, tx_be.data}), 64'd0);
        check("reset_addrs", 64'({reg_a_le, dm_a_le, reg_a_be, dm_a_be}), 64'd0);
        i_rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{3'b001, 32'h0000_0104, 5'd0,  6'd0,  0, 1'b1, 1'b0, 1'b0, 6};
        vecs[1] = '{3'b010, 32'h0,         5'd0,  6'd0,  0, 1'b0, 1'b0, 1'b0, 130};
        vecs[2] = '{3'b100, 32'h0,         5'd30, 6'd4,  0, 1'b0, 1'b0, 1'b0, 18};
        vecs[3] = '{3'b001, 32'h0000_0104, 5'd0,  6'd0,  1, 1'b1, 1'b0, 1'b0, 6};
        vecs[4] = '{3'b000, 32'hDEAD_BEEF, 5'd9,  6'd3,  0, 1'b0, 1'b0, 1'b1, 2};
        vecs[5] = '{3'b111, 32'h8765_4321, 5'd5,  6'd0,  2, 1'b0, 1'b1, 1'b0, 134};
        vecs[6] = '{3'b101, 32'hA5A5_0F0F, 5'd31, 6'd32, 2, 1'b0, 1'b0, 1'b0, 134};
        vecs[7] = '{3'b110, 32'h0,         5'd0,  6'd1,  1, 1'b0, 1'b1, 1'b0, 134};

        for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

        run_abort();
        run_frame(8, vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
